dllp_rx_proc: RTL and testbench

//  Data-link RX DLLP processor, directly downstream of the DLLP CRC checker.

---
 rtl/dllp_rx_proc.sv | 163 ++++++++++++++++
 tb/tb_dllp_rx_proc.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dllp_rx_proc.sv
// dllp_rx_proc: RX DLLP processor behind the DLLP CRC checker. Drops bad-CRC DLLPs,
// decodes Ack/Nak and FC DLLPs, runs the VC flow-control init FSM and holds TX credit limits.
module dllp_rx_proc #(
  parameter logic [2:0] VC_ID = 3'd0,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dl_init_start,
  input  logic             Dmux_vld_dllp,
  input  logic [63:0]      DLLP_Dmux_o,
  input  logic             CRC_CHK_vld_dllp,
  output logic             ack_vld,
  output logic             nak_vld,
  output logic [11:0]      acknak_seq,
  output logic [7:0]       fc_ph_lim,
  output logic [11:0]      fc_pd_lim,
  output logic [7:0]       fc_nph_lim,
  output logic [11:0]      fc_npd_lim,
  output logic [7:0]       fc_cplh_lim,
  output logic [11:0]      fc_cpld_lim,
  output logic [5:0]       fc_inf,
  output logic [1:0]       fc_state,
  output logic             dl_up,
  output logic             bad_crc,
  output logic [CNT_W-1:0] bad_crc_cnt
);

  typedef enum logic [1:0] {
    FC_IDLE   = 2'b00,
    FC_INIT1  = 2'b01,
    FC_INIT2  = 2'b10,
    FC_ACTIVE = 2'b11
  } fcState_e;

  fcState_e         state_q, state_d;
  logic [2:0][7:0]  hdrLim_q, hdrLim_d;
  logic [2:0][11:0] datLim_q, datLim_d;
  logic [2:0]       hdrInf_q, hdrInf_d;
  logic [2:0]       datInf_q, datInf_d;
  logic [2:0]       got_q, got_d;
  logic             ack_q, ack_d, nak_q, nak_d, bad_q, bad_d;
  logic [11:0]      seq_q, seq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        good, bad;
  logic [7:0]  dType;
  logic [7:0]  hdrFc;
  logic [11:0] datFc;
  logic [1:0]  fcCat;
  logic        fcOk, isInit1, isInit2, isUpd, isAck, isNak;
  logic        unusedBits;

  assign good  = Dmux_vld_dllp & CRC_CHK_vld_dllp;
  assign bad   = Dmux_vld_dllp & ~CRC_CHK_vld_dllp;
  assign dType = DLLP_Dmux_o[63:56];
  assign hdrFc = {DLLP_Dmux_o[53:48], DLLP_Dmux_o[47:46]};
  assign datFc = DLLP_Dmux_o[43:32];
  // Upper type nibble low bits select P/NP/Cpl identically for InitFC1, InitFC2 and UpdateFC
  assign fcCat   = dType[5:4];
  assign fcOk    = good && !dType[3] && (dType[2:0] == VC_ID) && (fcCat != 2'b11);
  assign isInit1 = fcOk && (dType[7:6] == 2'b01);
  assign isInit2 = fcOk && (dType[7:6] == 2'b11);
  assign isUpd   = fcOk && (dType[7:6] == 2'b10);
  assign isAck   = good && (dType == 8'h00);
  assign isNak   = good && (dType == 8'h10);
  assign unusedBits = ^{DLLP_Dmux_o[55:54], DLLP_Dmux_o[45:44], DLLP_Dmux_o[31:0]};

  always_comb begin
    state_d  = state_q;
    hdrLim_d = hdrLim_q;
    datLim_d = datLim_q;
    hdrInf_d = hdrInf_q;
    datInf_d = datInf_q;
    got_d    = got_q;
    seq_d    = seq_q;
    ack_d    = 1'b0;
    nak_d    = 1'b0;
    bad_d    = bad;
    cnt_d    = cnt_q;
    if (bad && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    if (!dl_init_start || (state_q == FC_IDLE)) begin
      state_d  = dl_init_start ? FC_INIT1 : FC_IDLE;
      hdrLim_d = '0;
      datLim_d = '0;
      hdrInf_d = '0;
      datInf_d = '0;
      got_d    = '0;
    end else begin
      unique case (state_q)
        FC_INIT1: begin
          // First InitFC of each type wins; a zero field advertises infinite credit
          if ((isInit1 || isInit2) && !got_q[fcCat]) begin
            hdrLim_d[fcCat] = hdrFc;
            datLim_d[fcCat] = datFc;
            hdrInf_d[fcCat] = (hdrFc == 8'd0);
            datInf_d[fcCat] = (datFc == 12'd0);
            got_d[fcCat]    = 1'b1;
          end
          if (&got_d) state_d = FC_INIT2;
        end
        FC_INIT2, FC_ACTIVE: begin
          if (isUpd) begin
            if (!hdrInf_q[fcCat]) hdrLim_d[fcCat] = hdrFc;
            if (!datInf_q[fcCat]) datLim_d[fcCat] = datFc;
          end
          if ((state_q == FC_INIT2) && (isInit2 || isUpd)) state_d = FC_ACTIVE;
          if ((state_q == FC_ACTIVE) && (isAck || isNak)) begin
            seq_d = datFc;
            ack_d = isAck;
            nak_d = isNak;
          end
        end
        default: state_d = FC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FC_IDLE;
      hdrLim_q <= '0;
      datLim_q <= '0;
      hdrInf_q <= '0;
      datInf_q <= '0;
      got_q    <= '0;
      seq_q    <= '0;
      ack_q    <= 1'b0;
      nak_q    <= 1'b0;
      bad_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hdrLim_q <= hdrLim_d;
      datLim_q <= datLim_d;
      hdrInf_q <= hdrInf_d;
      datInf_q <= datInf_d;
      got_q    <= got_d;
      seq_q    <= seq_d;
      ack_q    <= ack_d;
      nak_q    <= nak_d;
      bad_q    <= bad_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ack_vld     = ack_q;
  assign nak_vld     = nak_q;
  assign acknak_seq  = seq_q;
  assign fc_ph_lim   = hdrLim_q[0];
  assign fc_pd_lim   = datLim_q[0];
  assign fc_nph_lim  = hdrLim_q[1];
  assign fc_npd_lim  = datLim_q[1];
  assign fc_cplh_lim = hdrLim_q[2];
  assign fc_cpld_lim = datLim_q[2];
  assign fc_inf      = {datInf_q[2], hdrInf_q[2], datInf_q[1], hdrInf_q[1], datInf_q[0], hdrInf_q[0]};
  assign fc_state    = state_q;
  assign dl_up       = (state_q == FC_ACTIVE);
  assign bad_crc     = bad_q;
  assign bad_crc_cnt = cnt_q;

endmodule

// File: tb/tb_dllp_rx_proc.sv
// tb_dllp_rx_proc: directed plus randomized DLLP traffic for dllp_rx_proc, checked every
// cycle against a behavioural model of the FC init / Ack-Nak / CRC-drop rules.
`timescale 1ns/1ps
module tb_dllp_rx_proc;

  localparam logic [2:0] VC_ID   = 3'd0;
  localparam int         CNT_W   = 4;
  localparam int         CNT_MAX = (1 << CNT_W) - 1;

  localparam int ST_IDLE = 0, ST_INIT1 = 1, ST_INIT2 = 2, ST_ACTIVE = 3;
  localparam int K_NONE = 0, K_ACK = 1, K_NAK = 2, K_I1 = 3, K_I2 = 4, K_UP = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             dl_init_start;
  logic             Dmux_vld_dllp;
  logic [63:0]      DLLP_Dmux_o;
  logic             CRC_CHK_vld_dllp;
  logic             ack_vld, nak_vld;
  logic [11:0]      acknak_seq;
  logic [7:0]       fc_ph_lim, fc_nph_lim, fc_cplh_lim;
  logic [11:0]      fc_pd_lim, fc_npd_lim, fc_cpld_lim;
  logic [5:0]       fc_inf;
  logic [1:0]       fc_state;
  logic             dl_up;
  logic             bad_crc;
  logic [CNT_W-1:0] bad_crc_cnt;

  dllp_rx_proc #(.VC_ID(VC_ID), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .dl_init_start(dl_init_start),
    .Dmux_vld_dllp(Dmux_vld_dllp), .DLLP_Dmux_o(DLLP_Dmux_o), .CRC_CHK_vld_dllp(CRC_CHK_vld_dllp),
    .ack_vld(ack_vld), .nak_vld(nak_vld), .acknak_seq(acknak_seq),
    .fc_ph_lim(fc_ph_lim), .fc_pd_lim(fc_pd_lim), .fc_nph_lim(fc_nph_lim),
    .fc_npd_lim(fc_npd_lim), .fc_cplh_lim(fc_cplh_lim), .fc_cpld_lim(fc_cpld_lim),
    .fc_inf(fc_inf), .fc_state(fc_state), .dl_up(dl_up),
    .bad_crc(bad_crc), .bad_crc_cnt(bad_crc_cnt)
  );

  always #5 clk = ~clk;

  int checksTotal  = 0;
  int checksPassed = 0;

  // Reference model state: limits indexed P=0, NP=1, Cpl=2
  int mState;
  int mHdr [3];
  int mDat [3];
  bit mHdrInf [3];
  bit mDatInf [3];
  bit mGot [3];
  int mSeq, mCnt;
  bit mAck, mNak, mBad;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  function automatic void modelClear();
    for (int i = 0; i < 3; i++) begin
      mHdr[i] = 0; mDat[i] = 0; mHdrInf[i] = 1'b0; mDatInf[i] = 1'b0; mGot[i] = 1'b0;
    end
  endfunction

  function automatic void modelReset();
    modelClear();
    mState = ST_IDLE; mSeq = 0; mCnt = 0; mAck = 1'b0; mNak = 1'b0; mBad = 1'b0;
  endfunction

  function automatic void modelUpdate(input int cat, input int hdr, input int dat);
    if (!mHdrInf[cat]) mHdr[cat] = hdr;
    if (!mDatInf[cat]) mDat[cat] = dat;
  endfunction

  function automatic void modelStep(input bit init, input bit vld, input logic [63:0] d, input bit crc);
    logic [7:0] typ;
    int kind, cat, hdr, dat;
    typ  = d[63:56];
    hdr  = int'({d[53:48], d[47:46]});
    dat  = int'(d[43:32]);
    kind = K_NONE;
    cat  = 0;
    mAck = 1'b0;
    mNak = 1'b0;
    mBad = vld && !crc;
    if (mBad && mCnt < CNT_MAX) mCnt++;
    if (vld && crc) begin
      if (typ == 8'h00) kind = K_ACK;
      else if (typ == 8'h10) kind = K_NAK;
      else if (typ[3] == 1'b0 && typ[2:0] == VC_ID) begin
        case (typ[7:4])
          4'h4: begin kind = K_I1; cat = 0; end
          4'h5: begin kind = K_I1; cat = 1; end
          4'h6: begin kind = K_I1; cat = 2; end
          4'hC: begin kind = K_I2; cat = 0; end
          4'hD: begin kind = K_I2; cat = 1; end
          4'hE: begin kind = K_I2; cat = 2; end
          4'h8: begin kind = K_UP; cat = 0; end
          4'h9: begin kind = K_UP; cat = 1; end
          4'hA: begin kind = K_UP; cat = 2; end
          default: kind = K_NONE;
        endcase
      end
    end
    if (!init) begin
      mState = ST_IDLE;
      modelClear();
      return;
    end
    case (mState)
      ST_IDLE: begin
        modelClear();
        mState = ST_INIT1;
      end
      ST_INIT1: begin
        if ((kind == K_I1 || kind == K_I2) && !mGot[cat]) begin
          mHdr[cat] = hdr; mDat[cat] = dat;
          mHdrInf[cat] = (hdr == 0); mDatInf[cat] = (dat == 0);
          mGot[cat] = 1'b1;
        end
        if (mGot[0] && mGot[1] && mGot[2]) mState = ST_INIT2;
      end
      ST_INIT2: begin
        if (kind == K_UP) modelUpdate(cat, hdr, dat);
        if (kind == K_I2 || kind == K_UP) mState = ST_ACTIVE;
      end
      default: begin
        if (kind == K_UP) modelUpdate(cat, hdr, dat);
        if (kind == K_ACK) begin mSeq = dat; mAck = 1'b1; end
        if (kind == K_NAK) begin mSeq = dat; mNak = 1'b1; end
      end
    endcase
  endfunction

  task automatic checkAll();
    logic [5:0] infExp;
    infExp = {mDatInf[2], mHdrInf[2], mDatInf[1], mHdrInf[1], mDatInf[0], mHdrInf[0]};
    checkOutput("ack_vld",     32'(ack_vld),     32'(mAck));
    checkOutput("nak_vld",     32'(nak_vld),     32'(mNak));
    checkOutput("acknak_seq",  32'(acknak_seq),  mSeq);
    checkOutput("fc_ph_lim",   32'(fc_ph_lim),   mHdr[0]);
    checkOutput("fc_pd_lim",   32'(fc_pd_lim),   mDat[0]);
    checkOutput("fc_nph_lim",  32'(fc_nph_lim),  mHdr[1]);
    checkOutput("fc_npd_lim",  32'(fc_npd_lim),  mDat[1]);
    checkOutput("fc_cplh_lim", 32'(fc_cplh_lim), mHdr[2]);
    checkOutput("fc_cpld_lim", 32'(fc_cpld_lim), mDat[2]);
    checkOutput("fc_inf",      32'(fc_inf),      32'(infExp));
    checkOutput("fc_state",    32'(fc_state),    mState);
    checkOutput("dl_up",       32'(dl_up),       32'(mState == ST_ACTIVE));
    checkOutput("bad_crc",     32'(bad_crc),     32'(mBad));
    checkOutput("bad_crc_cnt", 32'(bad_crc_cnt), mCnt);
  endtask

  function automatic logic [63:0] mkFc(input logic [7:0] typ, input logic [7:0] hdr, input logic [11:0] dat);
    logic [63:0] d;
    d = '0;
    d[63:56] = typ;
    d[55:54] = 2'($urandom);
    d[53:48] = hdr[7:2];
    d[47:46] = hdr[1:0];
    d[45:44] = 2'($urandom);
    d[43:32] = dat;
    d[31:16] = 16'($urandom);
    return d;
  endfunction

  function automatic logic [63:0] randomDllp();
    logic [7:0] typ;
    logic [7:0] hdr;
    logic [11:0] dat;
    int sel;
    sel = int'($urandom_range(0, 11));
    hdr = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
    dat = ($urandom_range(0, 5) == 0) ? 12'd0 : 12'($urandom);
    case (sel)
      0: typ = 8'h00;
      1: typ = 8'h10;
      2: typ = 8'h40;  3: typ = 8'h50;  4: typ = 8'h60;
      5: typ = 8'hC0;  6: typ = 8'hD0;  7: typ = 8'hE0;
      8: typ = 8'h80;  9: typ = 8'h90;  10: typ = 8'hA0;
      default: typ = 8'($urandom);
    endcase
    if (sel >= 2 && sel <= 10) begin
      typ[2:0] = ($urandom_range(0, 9) == 0) ? 3'($urandom) : VC_ID;
      typ[3]   = ($urandom_range(0, 14) == 0);
    end
    return mkFc(typ, hdr, dat);
  endfunction

  // One DLLP slot: drive, let the DUT clock it, advance the model, then compare
  task automatic applyStimulus(input bit vld, input logic [63:0] d, input bit crc);
    Dmux_vld_dllp    = vld;
    DLLP_Dmux_o      = d;
    CRC_CHK_vld_dllp = crc;
    @(posedge clk);
    modelStep(dl_init_start, vld, d, crc);
    #1 checkAll();
  endtask

  task automatic asyncReset();
    Dmux_vld_dllp = 1'b0;
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    checkOutput("arst_dl_up", 32'(dl_up), 32'd0);
    @(posedge clk);
    #1 checkAll();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; dl_init_start = 1'b0;
    Dmux_vld_dllp = 1'b0; DLLP_Dmux_o = '0; CRC_CHK_vld_dllp = 1'b0;
    modelReset();
    @(posedge clk);
    #1 checkAll();
    @(posedge clk);
    #1 rst = 1'b0;

    // Bring-up: InitFC1 P/NP/Cpl, then InitFC2 to go active
    dl_init_start = 1'b1;
    applyStimulus(1'b0, 64'd0, 1'b0);
    applyStimulus(1'b1, 64'h4001_4080_0000_0000, 1'b1);
    checkOutput("t1_ph", 32'(fc_ph_lim), 32'h05);
    checkOutput("t1_pd", 32'(fc_pd_lim), 32'h080);
    checkOutput("t1_state", 32'(fc_state), 32'd1);
    applyStimulus(1'b1, mkFc(8'h00, 8'h00, 12'h055), 1'b1);
    checkOutput("ack_in_init1", 32'(ack_vld), 32'd0);
    applyStimulus(1'b1, mkFc(8'h50, 8'h00, 12'h040), 1'b1);
    applyStimulus(1'b1, mkFc(8'h60, 8'h20, 12'h000), 1'b1);
    checkOutput("t2_state_init2", 32'(fc_state), 32'd2);
    checkOutput("t2_inf_nph", 32'(fc_inf[2]), 32'd1);
    applyStimulus(1'b1, mkFc(8'hC0, 8'h11, 12'h111), 1'b1);
    checkOutput("t2_dl_up", 32'(dl_up), 32'd1);

    applyStimulus(1'b1, mkFc(8'h00, 8'h00, 12'h123), 1'b1);
    checkOutput("t3_ack", 32'(ack_vld), 32'd1);
    checkOutput("t3_seq", 32'(acknak_seq), 32'h123);
    applyStimulus(1'b0, 64'd0, 1'b1);
    checkOutput("t3_ack_pulse", 32'(ack_vld), 32'd0);
    applyStimulus(1'b1, mkFc(8'h10, 8'h00, 12'h7FF), 1'b1);
    checkOutput("t3_nak_seq", 32'(acknak_seq), 32'h7FF);

    applyStimulus(1'b1, mkFc(8'h00, 8'h00, 12'h456), 1'b0);
    checkOutput("t4_no_ack", 32'(ack_vld), 32'd0);
    checkOutput("t4_cnt", 32'(bad_crc_cnt), 32'd1);

    applyStimulus(1'b1, mkFc(8'h90, 8'h33, 12'h200), 1'b1);
    checkOutput("t5_nph_inf", 32'(fc_nph_lim), 32'd0);
    checkOutput("t5_npd", 32'(fc_npd_lim), 32'h200);
    applyStimulus(1'b1, mkFc(8'h91, 8'h44, 12'h300), 1'b1);
    checkOutput("t5_vc1_npd", 32'(fc_npd_lim), 32'h200);

    repeat (CNT_MAX + 4) applyStimulus(1'b1, randomDllp(), 1'b0);
    checkOutput("t4_saturate", 32'(bad_crc_cnt), CNT_MAX);

    asyncReset();

    // Drop link-up in the middle of INIT1
    applyStimulus(1'b0, 64'd0, 1'b0);
    applyStimulus(1'b1, mkFc(8'h40, 8'h22, 12'h000), 1'b1);
    checkOutput("t6_pd_inf", 32'(fc_inf[1]), 32'd1);
    dl_init_start = 1'b0;
    applyStimulus(1'b1, mkFc(8'h50, 8'h07, 12'h070), 1'b1);
    checkOutput("t6_idle", 32'(fc_state), 32'd0);
    checkOutput("t6_inf_clr", 32'(fc_inf), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      if (!dl_init_start) dl_init_start = 1'b1;
      else if ($urandom_range(0, 199) == 0) dl_init_start = 1'b0;
      applyStimulus($urandom_range(0, 99) < 80, randomDllp(), $urandom_range(0, 99) < 88);
      if (n == 1500) asyncReset();
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
